// File: rtl/if_id_hazard_reg.sv
// IF/ID pipeline register with load-use hazard detection and a multi-cycle
// branch flush sequencer that squashes FLUSH_SLOTS fetched instructions.
module if_id_hazard_reg #(
  parameter int unsigned FLUSH_SLOTS = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      inInstr,
  input  logic [31:0]      inPCPlus4,
  input  logic             Flush,
  input  logic             exMemRead,
  input  logic [4:0]       exRt,
  output logic [31:0]      outInstr,
  output logic [31:0]      outPCPlus4,
  output logic             PCWrite,
  output logic             CtrlBubble,
  output logic             Flushing,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [2:0]       RELOAD  = 3'(FLUSH_SLOTS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  state_t           r_state;
  logic [2:0]       r_flush_cnt;
  logic [31:0]      r_instr;
  logic [31:0]      r_pc4;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_evt;

  state_t           w_state_nxt;
  logic [2:0]       w_cnt_nxt;
  logic [31:0]      w_instr_nxt;
  logic [31:0]      w_pc4_nxt;
  logic             w_stall_inc;
  logic             w_flush_inc;

  logic [5:0]       w_op;
  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic             w_rt_is_src;
  logic             w_hazard;

  assign w_op = r_instr[31:26];
  assign w_rs = r_instr[25:21];
  assign w_rt = r_instr[20:16];

  // Opcodes that read rt as a source operand (R-type, stores, beq/bne).
  always_comb begin
    w_rt_is_src = 1'b0;
    case (w_op)
      OP_RTYPE, OP_SW, OP_SH, OP_SB, OP_BEQ, OP_BNE: w_rt_is_src = 1'b1;
      default:                                       w_rt_is_src = 1'b0;
    endcase
  end

  // exMemRead gates the compare first, so an unknown exRt on a non-load
  // cannot reach PCWrite or CtrlBubble.
  assign w_hazard = (r_state == RUN) && exMemRead && (exRt != 5'd0) &&
                    ((exRt == w_rs) || ((exRt == w_rt) && w_rt_is_src));

  assign PCWrite    = !w_hazard;
  assign CtrlBubble = w_hazard;

  // NOTE: every signal is given a default before the case so that no path
  // leaves one unassigned; a missed assignment in always_comb infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_flush_cnt;
    w_instr_nxt = r_instr;
    w_pc4_nxt   = r_pc4;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;

    case (r_state)
      RUN: begin
        if (Flush) begin
          w_instr_nxt = 32'd0;
          w_pc4_nxt   = 32'd0;
          w_flush_inc = 1'b1;
          if (FLUSH_SLOTS > 1) begin
            w_state_nxt = FLUSH;
            w_cnt_nxt   = RELOAD;
          end
        end else if (w_hazard) begin
          w_stall_inc = 1'b1;
        end else begin
          w_instr_nxt = inInstr;
          w_pc4_nxt   = inPCPlus4;
        end
      end

      FLUSH: begin
        w_instr_nxt = 32'd0;
        w_pc4_nxt   = 32'd0;
        if (Flush) begin
          w_cnt_nxt   = RELOAD;
          w_flush_inc = 1'b1;
        end else begin
          w_cnt_nxt = r_flush_cnt - 3'd1;
          if (r_flush_cnt == 3'd1) begin
            w_state_nxt = RUN;
          end
        end
      end

      default: w_state_nxt = RUN;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= RUN;
      r_flush_cnt <= 3'd0;
      r_instr     <= 32'd0;
      r_pc4       <= 32'd0;
      r_stall_cnt <= '0;
      r_flush_evt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_cnt_nxt;
      r_instr     <= w_instr_nxt;
      r_pc4       <= w_pc4_nxt;
      if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_flush_inc && (r_flush_evt != CNT_MAX)) begin
        r_flush_evt <= r_flush_evt + CNT_ONE;
      end
    end
  end

  assign outInstr   = r_instr;
  assign outPCPlus4 = r_pc4;
  assign Flushing   = (r_state == FLUSH);
  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_evt;

endmodule

// File: tb/tb_if_id_hazard_reg.sv
// Directed bench for if_id_hazard_reg: stream, load-use stall, flush window,
// flush/hazard priority, reset mid-flush and stall counter saturation.
module tb_if_id_hazard_reg;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] inInstr;
  logic [31:0] inPCPlus4;
  logic        Flush;
  logic        exMemRead;
  logic [4:0]  exRt;
  logic [31:0] outInstr;
  logic [31:0] outPCPlus4;
  logic        PCWrite;
  logic        CtrlBubble;
  logic        Flushing;
  logic [15:0] StallCount;
  logic [15:0] FlushCount;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  if_id_hazard_reg #(
    .FLUSH_SLOTS(3),
    .CNT_W      (16)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .inInstr   (inInstr),
    .inPCPlus4 (inPCPlus4),
    .Flush     (Flush),
    .exMemRead (exMemRead),
    .exRt      (exRt),
    .outInstr  (outInstr),
    .outPCPlus4(outPCPlus4),
    .PCWrite   (PCWrite),
    .CtrlBubble(CtrlBubble),
    .Flushing  (Flushing),
    .StallCount(StallCount),
    .FlushCount(FlushCount)
  );

  // Advance one clock and settle just past the edge.
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1; inInstr = 32'h0; inPCPlus4 = 32'h0;
    Flush = 1'b0; exMemRead = 1'b0; exRt = 5'd0;
    #3;
    checks++; if (outInstr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h want=%h", outInstr, 32'h0); end
    checks++; if (outPCPlus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h want=%h", outPCPlus4, 32'h0); end
    checks++; if (Flushing !== 1'b0) begin errors++; $display("FAIL reset_flushing got=%b want=0", Flushing); end
    checks++; if (StallCount !== 16'h0) begin errors++; $display("FAIL reset_stallcnt got=%h want=0", StallCount); end
    checks++; if (FlushCount !== 16'h0) begin errors++; $display("FAIL reset_flushcnt got=%h want=0", FlushCount); end
    checks++; if (PCWrite !== 1'b1 || CtrlBubble !== 1'b0) begin errors++; $display("FAIL reset_hazard got=%b%b want=10", PCWrite, CtrlBubble); end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_stream;
    inInstr = 32'h8C080000; inPCPlus4 = 32'd4;
    tick();
    checks++; if (outInstr !== 32'h8C080000) begin errors++; $display("FAIL stream_lw got=%h want=%h", outInstr, 32'h8C080000); end
    checks++; if (outPCPlus4 !== 32'd4) begin errors++; $display("FAIL stream_pc4a got=%0d want=4", outPCPlus4); end
    inInstr = 32'h01094020; inPCPlus4 = 32'd8;
    tick();
    checks++; if (outInstr !== 32'h01094020) begin errors++; $display("FAIL stream_add got=%h want=%h", outInstr, 32'h01094020); end
    checks++; if (outPCPlus4 !== 32'd8) begin errors++; $display("FAIL stream_pc4b got=%0d want=8", outPCPlus4); end
  endtask

  task automatic test_load_use;
    // lw $8 now in EX, add reads $8 as rs.
    exMemRead = 1'b1; exRt = 5'd8;
    inInstr = 32'h012A5820; inPCPlus4 = 32'd12;
    #1;
    checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL lu_pcwrite got=%b want=0", PCWrite); end
    checks++; if (CtrlBubble !== 1'b1) begin errors++; $display("FAIL lu_bubble got=%b want=1", CtrlBubble); end
    tick();
    checks++; if (outInstr !== 32'h01094020) begin errors++; $display("FAIL lu_hold got=%h want=%h", outInstr, 32'h01094020); end
    checks++; if (outPCPlus4 !== 32'd8) begin errors++; $display("FAIL lu_hold_pc got=%0d want=8", outPCPlus4); end
    checks++; if (StallCount !== 16'd1) begin errors++; $display("FAIL lu_stallcnt got=%0d want=1", StallCount); end
    exMemRead = 1'b0;
    #1;
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL lu_resume_pcw got=%b want=1", PCWrite); end
    tick();
    checks++; if (outInstr !== 32'h012A5820) begin errors++; $display("FAIL lu_resume got=%h want=%h", outInstr, 32'h012A5820); end
    // R-type with exRt matching rt ($10).
    exMemRead = 1'b1; exRt = 5'd10;
    #1;
    checks++; if (CtrlBubble !== 1'b1) begin errors++; $display("FAIL lu_rtype_rt got=%b want=1", CtrlBubble); end
    // sw $9,0($8): rt is the store data source.
    exMemRead = 1'b0;
    inInstr = 32'hAD090000; inPCPlus4 = 32'd16;
    tick();
    exMemRead = 1'b1; exRt = 5'd9;
    #1;
    checks++; if (CtrlBubble !== 1'b1 || PCWrite !== 1'b0) begin errors++; $display("FAIL lu_sw_rt got=%b%b want=10", PCWrite, CtrlBubble); end
    exMemRead = 1'b0;
  endtask

  task automatic test_no_hazard;
    inInstr = 32'h3C080005; inPCPlus4 = 32'd20;
    tick();
    // lui: rs=0, rt=8 is a destination, not a source.
    exMemRead = 1'b1; exRt = 5'd8;
    #1;
    checks++; if (PCWrite !== 1'b1 || CtrlBubble !== 1'b0) begin errors++; $display("FAIL nh_lui got=%b%b want=10", PCWrite, CtrlBubble); end
    exRt = 5'd0;
    #1;
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL nh_rt_zero got=%b want=1", PCWrite); end
    exMemRead = 1'b0; exRt = 5'bxxxxx;
    #1;
    checks++; if (PCWrite !== 1'b1 || CtrlBubble !== 1'b0) begin errors++; $display("FAIL nh_x_rt got=%b%b want=10", PCWrite, CtrlBubble); end
    exRt = 5'd0;
  endtask

  task automatic test_flush;
    inInstr = 32'h01094020; inPCPlus4 = 32'd24;
    tick();
    Flush = 1'b1; inInstr = 32'h22222222; inPCPlus4 = 32'd28;
    tick();
    checks++; if (outInstr !== 32'h0 || outPCPlus4 !== 32'h0) begin errors++; $display("FAIL fl_nop1 got=%h/%h want=0/0", outInstr, outPCPlus4); end
    checks++; if (Flushing !== 1'b1) begin errors++; $display("FAIL fl_flushing1 got=%b want=1", Flushing); end
    checks++; if (FlushCount !== 16'd1) begin errors++; $display("FAIL fl_count got=%0d want=1", FlushCount); end
    Flush = 1'b0; exMemRead = 1'b1; exRt = 5'd8;
    #1;
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL fl_hz_ignored got=%b want=1", PCWrite); end
    tick();
    checks++; if (outInstr !== 32'h0 || Flushing !== 1'b1) begin errors++; $display("FAIL fl_nop2 got=%h/%b want=0/1", outInstr, Flushing); end
    tick();
    checks++; if (outInstr !== 32'h0 || Flushing !== 1'b0) begin errors++; $display("FAIL fl_nop3 got=%h/%b want=0/0", outInstr, Flushing); end
    exMemRead = 1'b0;
    tick();
    checks++; if (outInstr !== 32'h22222222 || outPCPlus4 !== 32'd28) begin errors++; $display("FAIL fl_reload got=%h/%0d want=22222222/28", outInstr, outPCPlus4); end
    checks++; if (StallCount !== 16'd1) begin errors++; $display("FAIL fl_stall_unch got=%0d want=1", StallCount); end
  endtask

  task automatic test_flush_hazard;
    inInstr = 32'h01094020; inPCPlus4 = 32'd32;
    tick();
    exMemRead = 1'b1; exRt = 5'd8; Flush = 1'b1;
    inInstr = 32'h33333333; inPCPlus4 = 32'd36;
    tick();
    checks++; if (outInstr !== 32'h0) begin errors++; $display("FAIL fh_nop got=%h want=0", outInstr); end
    checks++; if (StallCount !== 16'd1) begin errors++; $display("FAIL fh_stall_unch got=%0d want=1", StallCount); end
    checks++; if (FlushCount !== 16'd2) begin errors++; $display("FAIL fh_count2 got=%0d want=2", FlushCount); end
    exMemRead = 1'b0; Flush = 1'b0;
    tick();
    checks++; if (Flushing !== 1'b1) begin errors++; $display("FAIL fh_in_flush got=%b want=1", Flushing); end
    Flush = 1'b1;
    tick();
    checks++; if (FlushCount !== 16'd3 || outInstr !== 32'h0) begin errors++; $display("FAIL fh_reflush got=%0d/%h want=3/0", FlushCount, outInstr); end
    Flush = 1'b0;
    tick();
    checks++; if (Flushing !== 1'b1 || outInstr !== 32'h0) begin errors++; $display("FAIL fh_extended got=%b/%h want=1/0", Flushing, outInstr); end
    tick();
    checks++; if (Flushing !== 1'b0 || outInstr !== 32'h0) begin errors++; $display("FAIL fh_last_nop got=%b/%h want=0/0", Flushing, outInstr); end
    tick();
    checks++; if (outInstr !== 32'h33333333) begin errors++; $display("FAIL fh_reload got=%h want=33333333", outInstr); end
  endtask

  task automatic test_reset_mid_flush;
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    tick();
    Reset = 1'b1;
    #1;
    checks++; if (outInstr !== 32'h0 || outPCPlus4 !== 32'h0) begin errors++; $display("FAIL rmf_outs got=%h/%h want=0/0", outInstr, outPCPlus4); end
    checks++; if (Flushing !== 1'b0) begin errors++; $display("FAIL rmf_state got=%b want=0", Flushing); end
    checks++; if (StallCount !== 16'h0 || FlushCount !== 16'h0) begin errors++; $display("FAIL rmf_counts got=%0d/%0d want=0/0", StallCount, FlushCount); end
    #1;
    Reset = 1'b0;
    inInstr = 32'h44444444; inPCPlus4 = 32'd40;
    tick();
    checks++; if (outInstr !== 32'h44444444 || Flushing !== 1'b0) begin errors++; $display("FAIL rmf_run got=%h/%b want=44444444/0", outInstr, Flushing); end
  endtask

  task automatic test_saturation;
    inInstr = 32'h01094020; inPCPlus4 = 32'd44;
    tick();
    exMemRead = 1'b1; exRt = 5'd8;
    repeat (65534) tick();
    checks++; if (StallCount !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got=%h want=fffe", StallCount); end
    repeat (7) tick();
    checks++; if (StallCount !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h want=ffff", StallCount); end
    checks++; if (outInstr !== 32'h01094020) begin errors++; $display("FAIL sat_instr got=%h want=01094020", outInstr); end
    exMemRead = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_flush_hazard();
    test_reset_mid_flush();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_hazard_reg.md
Name: if_id_hazard_reg

Overview:
- IF/ID pipeline register with an integrated load-use hazard unit and a multi-cycle branch flush sequencer.
- Sits between instruction fetch and decode, directly upstream of the ID/EX register.
- Holds the fetched instruction and PC+4 for decode.
- Stalls fetch and requests a control bubble into ID/EX on a load-use hazard.
- Squashes fetched instructions for a programmable number of cycles when a branch resolves taken.

Parameters:
- FLUSH_SLOTS, 3: number of consecutive cycles the register outputs NOP after Flush. Legal range 1..7.
- CNT_W, 16: width of the saturating bubble/flush event counters.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  reset, asynchronous, active-high.
- inInstr  input  32  instruction from instruction memory.
- inPCPlus4  input  32  PC+4 of the fetched instruction.
- Flush  input  1  branch/jump resolved taken; squash the younger instructions.
- exMemRead  input  1  MemRead of the instruction currently in EX (ID/EX output).
- exRt  input  5  rt (load destination) of the instruction currently in EX.
- outInstr  output  32  registered instruction presented to decode.
- outPCPlus4  output  32  registered PC+4 presented to decode.
- PCWrite  output  1  combinational; 0 freezes the PC this cycle.
- CtrlBubble  output  1  combinational; 1 forces ID/EX control inputs to zero this cycle.
- Flushing  output  1  registered; 1 while in the FLUSH state.
- StallCount  output  CNT_W  saturating count of load-use stall cycles.
- FlushCount  output  CNT_W  saturating count of Flush assertions accepted.

Behaviour:
- Reset values (asynchronous): outInstr=0 (NOP), outPCPlus4=0, state=RUN, flush counter=0, Flushing=0, StallCount=0, FlushCount=0.
- Derived fields from outInstr: op=[31:26], rs=[25:21], rt=[20:16].
- Rt-as-source instructions: op=000000 (R-type), sw 101011, sh 101001, sb 101000, beq 000100, bne 000101.
- hazard = exMemRead && exRt!=0 && (exRt==rs || (exRt==rt && rt-as-source)).
  - hazard is forced to 0 while in the FLUSH state.
- PCWrite = !hazard. CtrlBubble = hazard. Both are purely combinational with no added latency.
- Two states: RUN and FLUSH.
- RUN, priority order:
  1. Flush=1: outInstr<=0, outPCPlus4<=0, FlushCount+1. If FLUSH_SLOTS>1, go to FLUSH with counter=FLUSH_SLOTS-1; otherwise stay in RUN. Flush overrides hazard in the same cycle.
  2. hazard=1: outInstr and outPCPlus4 hold, StallCount+1, stay in RUN. A hazard normally lasts 1 cycle, since the next cycle's EX holds a bubble.
  3. Otherwise: outInstr<=inInstr, outPCPlus4<=inPCPlus4.
- FLUSH:
  - Each cycle: outInstr<=0, outPCPlus4<=0, counter-1.
  - When counter==1, the next state is RUN.
  - Total NOP cycles from the Flush edge is exactly FLUSH_SLOTS.
  - Flush asserted again while in FLUSH: counter reloads to FLUSH_SLOTS-1 and FlushCount+1.
- Flushing = (state==FLUSH), registered.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-flush or mid-stall returns all state to reset values immediately. The first posedge after Reset deasserts behaves as RUN.
- No X propagation: an X on exRt while exMemRead=0 must not affect outputs.

Test Plan:
- Reset, then an instruction stream 0x8C080000 (lw $8), 0x01094020 (add $8,$8,$9), PC+4=4,8 → outInstr follows inInstr with 1-cycle latency; outPCPlus4=4 then 8.
- outInstr=0x01094020 with exMemRead=1, exRt=8 → PCWrite=0, CtrlBubble=1, outInstr held 1 cycle, StallCount=1. Next cycle exMemRead=0 → load resumes.
- outInstr=0x3C080005 (lui, rt not a source) with exMemRead=1, exRt=8 → no hazard, PCWrite=1. Same check with exRt=0 and rs=0 → no hazard.
- Flush=1 for 1 cycle, FLUSH_SLOTS=3 → outInstr=0 for exactly 3 cycles, Flushing=1 for 2 cycles, FlushCount=1, then inInstr loads again. Hazard inputs asserted during FLUSH are ignored.
- Flush and hazard in the same cycle → flush wins, StallCount unchanged. A second Flush during FLUSH → NOP window extends, FlushCount=2.
- Reset pulsed in the 2nd flush cycle → outputs 0, state RUN, counters 0. After 2^CNT_W+5 forced stalls, StallCount holds at 0xFFFF.
